// File: rtl/bus_trace.sv
// Bus-cycle capture buffer: records {wr, addr, data} samples into a circular
// buffer around an address trigger, then streams the window out via valid/ready.
module bus_trace #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          bus_addr,
    input  logic [DATA_W-1:0]          bus_rd_data,
    input  logic [DATA_W-1:0]          bus_wr_data,
    input  logic                       bus_wr_enable,
    input  logic                       arm,
    input  logic [ADDR_W-1:0]          trig_addr,
    input  logic [ADDR_W-1:0]          trig_mask,
    input  logic                       trig_on_write,
    input  logic [DEPTH_LOG2:0]        post_count,
    output logic [1:0]                 state,
    output logic                       triggered,
    output logic                       done,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [ADDR_W+DATA_W:0]     rd_entry
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam logic [DEPTH_LOG2:0]   FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   MAX_POST = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, wr_ptr_inc;
    logic [DEPTH_LOG2:0]     fill, remaining, rd_left, fill_inc, post_clamped, post_q;
    logic [ADDR_W-1:0]       trig_addr_q, trig_mask_q;
    logic                    trig_on_write_q;
    logic                    match, capture, handshake, enter_done;
    logic [ENTRY_W-1:0]      sample_entry;

    // Clamping keeps the trigger sample inside the window.
    assign post_clamped = (post_count > MAX_POST) ? MAX_POST : post_count;

    assign match = enable
                && (((bus_addr ^ trig_addr_q) & trig_mask_q) == '0)
                && (!trig_on_write_q || bus_wr_enable);
    assign sample_entry = {bus_wr_enable, bus_addr, bus_wr_enable ? bus_wr_data : bus_rd_data};
    assign capture      = !arm && enable && (state_q == ARMED || state_q == POST);
    assign handshake    = rd_valid && rd_ready;
    assign wr_ptr_inc   = wr_ptr + PTR_ONE;
    assign fill_inc     = (fill == FULL) ? fill : fill + CNT_ONE;
    assign enter_done   = !arm && (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (arm) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED:   if (match) state_d = (post_q == '0) ? DONE : POST;
                POST:    if (enable && remaining == CNT_ONE) state_d = DONE;
                DONE:    if (handshake && rd_left == CNT_ONE) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fill            <= '0;
            remaining       <= '0;
            rd_left         <= '0;
            triggered       <= 1'b0;
            trig_addr_q     <= '0;
            trig_mask_q     <= '0;
            trig_on_write_q <= 1'b0;
            post_q          <= '0;
        end else if (arm) begin
            wr_ptr          <= '0;
            fill            <= '0;
            rd_left         <= '0;
            triggered       <= 1'b0;
            trig_addr_q     <= trig_addr;
            trig_mask_q     <= trig_mask;
            trig_on_write_q <= trig_on_write;
            post_q          <= post_clamped;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr_inc;
                fill   <= fill_inc;
            end
            if (state_q == ARMED && match) begin
                triggered <= 1'b1;
                remaining <= post_q;
            end
            if (state_q == POST && enable) remaining <= remaining - CNT_ONE;
            // The oldest entry sits fill slots behind the post-write pointer.
            if (enter_done) begin
                rd_ptr  <= wr_ptr_inc - fill_inc[DEPTH_LOG2-1:0];
                rd_left <= fill_inc;
            end else if (handshake) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_left <= rd_left - CNT_ONE;
            end
        end
    end

    // NOTE: the buffer RAM has no reset; stale contents are never presented because rd_entry is gated by rd_valid.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= sample_entry;
    end

    always_comb begin
        state    = state_q;
        done     = (state_q == DONE);
        rd_valid = (state_q == DONE) && (rd_left != '0);
        rd_entry = rd_valid ? mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_bus_trace.sv
// Self-checking bench for bus_trace: directed scenarios plus randomized traffic
// compared each cycle against a queue-based behavioural model.
module tb_bus_trace;

    typedef logic [24:0] entry_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] bus_addr = '0;
    logic [7:0]  bus_rd_data = '0;
    logic [7:0]  bus_wr_data = '0;
    logic        bus_wr_enable = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] trig_addr = '0;
    logic [15:0] trig_mask = '0;
    logic        trig_on_write = 1'b0;
    logic [3:0]  post_count = '0;
    logic [1:0]  state;
    logic        triggered;
    logic        done;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    entry_t      rd_entry;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: list of stored samples, readout = last 8 of them.
    int          m_state = 0;
    bit          m_trig = 0;
    int          m_post = 0;
    int          m_left = 0;
    logic [15:0] m_ta = '0;
    logic [15:0] m_tm = '0;
    bit          m_tw = 0;
    entry_t      m_hist[$];
    entry_t      m_out[$];
    entry_t      got[$];

    bus_trace #(.ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus_addr(bus_addr),
        .bus_rd_data(bus_rd_data), .bus_wr_data(bus_wr_data),
        .bus_wr_enable(bus_wr_enable), .arm(arm), .trig_addr(trig_addr),
        .trig_mask(trig_mask), .trig_on_write(trig_on_write),
        .post_count(post_count), .state(state), .triggered(triggered),
        .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_entry(rd_entry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_capture();
        while (m_hist.size() > 8) void'(m_hist.pop_front());
        m_out   = m_hist;
        m_state = 3;
    endtask

    task automatic model_step();
        entry_t s;
        s = {bus_wr_enable, bus_addr, bus_wr_enable ? bus_wr_data : bus_rd_data};
        if (reset) begin
            m_state = 0;
            m_trig  = 0;
            m_out.delete();
        end else if (arm) begin
            m_ta    = trig_addr;
            m_tm    = trig_mask;
            m_tw    = trig_on_write;
            m_post  = (int'(post_count) > 7) ? 7 : int'(post_count);
            m_trig  = 0;
            m_state = 1;
            m_hist.delete();
            m_out.delete();
        end else begin
            case (m_state)
                1: if (enable) begin
                    m_hist.push_back(s);
                    if (((bus_addr ^ m_ta) & m_tm) == 16'h0 && (!m_tw || bus_wr_enable)) begin
                        m_trig = 1;
                        if (m_post == 0) finish_capture();
                        else begin
                            m_left  = m_post;
                            m_state = 2;
                        end
                    end
                end
                2: if (enable) begin
                    m_hist.push_back(s);
                    m_left--;
                    if (m_left == 0) finish_capture();
                end
                3: if (rd_ready && m_out.size() > 0) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0) m_state = 0;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: log any DUT handshake, advance the model, then compare outputs.
    task automatic tick();
        bit     exp_valid;
        entry_t exp_entry;
        if (rd_valid && rd_ready) got.push_back(rd_entry);
        model_step();
        @(posedge clk);
        #1;
        exp_valid = (m_state == 3) && (m_out.size() > 0);
        exp_entry = exp_valid ? m_out[0] : '0;
        check("state", 32'(state), 32'(m_state));
        check("triggered", 32'(triggered), 32'(m_trig));
        check("done", 32'(done), 32'(m_state == 3));
        check("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check("rd_entry", 32'(rd_entry), 32'(exp_entry));
    endtask

    task automatic do_arm(input logic [15:0] ta, input logic [15:0] tm,
                          input logic tw, input logic [3:0] pc);
        trig_addr     = ta;
        trig_mask     = tm;
        trig_on_write = tw;
        post_count    = pc;
        arm           = 1'b1;
        tick();
        arm = 1'b0;
        got.delete();
    endtask

    task automatic feed(input logic [15:0] a, input logic [7:0] d, input logic we);
        enable        = 1'b1;
        bus_addr      = a;
        bus_wr_enable = we;
        bus_wr_data   = we ? d : 8'($urandom);
        bus_rd_data   = we ? 8'($urandom) : d;
        tick();
        enable = 1'b0;
    endtask

    // Read out until the model says the window is empty; rd_ready high one cycle in `duty`.
    task automatic drain(input int duty);
        entry_t held;
        bit     stalled;
        stalled = 0;
        held    = '0;
        for (int c = 0; c < 200 && m_state == 3; c++) begin
            rd_ready = ((c % duty) == 0);
            if (stalled) check("stall_hold", 32'(rd_entry), 32'(held));
            stalled = rd_valid && !rd_ready;
            held    = rd_entry;
            tick();
        end
        rd_ready = 1'b0;
        check("drain_done", 32'(done), 32'd0);
    endtask

    task automatic check_addrs(input string tag, input logic [15:0] exp[], input int n);
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++)
            check(tag, (i < got.size()) ? 32'(got[i][23:8]) : 32'hDEAD, 32'(exp[i]));
    endtask

    initial begin
        logic [15:0] exp_a[];

        // 1. Reset while arm is driven.
        reset = 1'b1;
        arm   = 1'b1;
        repeat (2) begin
            tick();
            check("rst_state", 32'(state), 32'd0);
            check("rst_trig", 32'(triggered), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_valid", 32'(rd_valid), 32'd0);
        end
        reset = 1'b0;
        arm   = 1'b0;
        tick();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_valid", 32'(rd_valid), 32'd0);

        // 2. Full window around 0xFFFC, post_count = 2.
        do_arm(16'hFFFC, 16'hFFFF, 1'b0, 4'd2);
        for (int i = 0; i < 5; i++) feed(16'(i), 8'($urandom), 1'b0);
        feed(16'hFFFC, 8'h5A, 1'b0);
        check("s2_trig", 32'(triggered), 32'd1);
        feed(16'h0010, 8'($urandom), 1'b0);
        check("s2_not_done", 32'(done), 32'd0);
        feed(16'h0011, 8'($urandom), 1'b0);
        check("s2_done", 32'(done), 32'd1);
        feed(16'h0012, 8'($urandom), 1'b0);
        drain(1);
        exp_a = new[8];
        exp_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hFFFC, 16'h0010, 16'h0011};
        check_addrs("s2_addr", exp_a, 8);

        // 3. Wrap-around with post_count = 0.
        do_arm(16'h0200, 16'hFFFF, 1'b0, 4'd0);
        for (int i = 0; i < 12; i++) feed(16'h0100 + 16'(i), 8'($urandom), 1'b0);
        feed(16'h0200, 8'($urandom), 1'b0);
        drain(1);
        exp_a = '{16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109, 16'h010A, 16'h010B, 16'h0200};
        check_addrs("s3_addr", exp_a, 8);

        // 4. Masked write-only trigger.
        do_arm(16'h0100, 16'hFF00, 1'b1, 4'd0);
        feed(16'h01FF, 8'h11, 1'b0);
        check("s4_no_trig", 32'(triggered), 32'd0);
        feed(16'h0150, 8'hAA, 1'b1);
        check("s4_trig", 32'(triggered), 32'd1);
        drain(1);
        check("s4_count", 32'(got.size()), 32'd2);
        check("s4_entry", (got.size() == 2) ? 32'(got[1]) : 32'hDEAD, 32'({1'b1, 16'h0150, 8'hAA}));

        // 5. Partial fill with 1/3-duty backpressure.
        do_arm(16'h3000, 16'hFFFF, 1'b0, 4'd1);
        for (int i = 0; i < 3; i++) feed(16'h2000 + 16'(i), 8'($urandom), 1'b0);
        feed(16'h3000, 8'($urandom), 1'b0);
        feed(16'h2100, 8'($urandom), 1'b0);
        drain(3);
        exp_a = new[5];
        exp_a = '{16'h2000, 16'h2001, 16'h2002, 16'h3000, 16'h2100};
        check_addrs("s5_addr", exp_a, 5);
        check("s5_idle", 32'(state), 32'd0);

        // 6. Clamp post_count and restart mid-readout.
        do_arm(16'h4000, 16'hFFFF, 1'b0, 4'd12);
        for (int i = 0; i < 2; i++) feed(16'h1000 + 16'(i), 8'($urandom), 1'b0);
        feed(16'h4000, 8'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) feed(16'h5000 + 16'(i), 8'($urandom), 1'b0);
        check("s6_done", 32'(done), 32'd1);
        rd_ready = 1'b1;
        repeat (3) tick();
        check("s6_first", (got.size() > 0) ? 32'(got[0][23:8]) : 32'hDEAD, 32'h4000);
        arm = 1'b1;
        tick();
        arm      = 1'b0;
        rd_ready = 1'b0;
        check("s6_valid", 32'(rd_valid), 32'd0);
        check("s6_state", 32'(state), 32'd1);
        check("s6_trig", 32'(triggered), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 30; k++) begin
            do_arm(16'($urandom_range(0, 7)),
                   ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0006,
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            for (int c = 0; c < 60; c++) begin
                enable        = ($urandom_range(0, 3) != 0);
                bus_addr      = 16'($urandom_range(0, 7));
                bus_rd_data   = 8'($urandom);
                bus_wr_data   = 8'($urandom);
                bus_wr_enable = 1'($urandom_range(0, 1));
                rd_ready      = 1'($urandom_range(0, 1));
                arm           = ($urandom_range(0, 49) == 0);
                reset         = ($urandom_range(0, 149) == 0);
                tick();
            end
            enable   = 1'b0;
            arm      = 1'b0;
            reset    = 1'b0;
            rd_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
